// File: rtl/sram_upload.sv
// Save-RAM uploader: serves cartridge RAM bytes to hps_io on upload.
// Optional autosave on quiet frames: define SRAM_UPLOAD_AUTOSAVE_EN.
module sram_upload #(
    parameter int          ADDR_W          = 13,
    parameter logic [7:0]  SAVE_INDEX      = 8'd1,
    parameter int          AUTOSAVE_FRAMES = 120
) (
    input  logic              CLK,
    input  logic              RESB,
    input  logic              SAVE_TRIG,
    input  logic              VSYNC,
    input  logic              IOCTL_UPLOAD,
    input  logic [7:0]        IOCTL_INDEX,
    input  logic              IOCTL_RD,
    input  logic [24:0]       IOCTL_ADDR,
    output logic [7:0]        IOCTL_DIN,
    output logic              IOCTL_WAIT,
    output logic              UPLOAD_REQ,
    output logic              MEM_RD,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [7:0]        MEM_DATA,
    input  logic              MEM_VALID,
    input  logic              MEM_WE_SNOOP,
    output logic              DIRTY,
    output logic              BUSY
);

    typedef enum logic [1:0] {IDLE, REQ, ACTIVE, FETCH} state_t;

    state_t              state, state_nxt;
    logic                sel;
    logic                in_range;
    logic                save_go;
    logic                clr_dirty;
    logic [7:0]          din_nxt;
    logic                wait_nxt;
    logic                rd_nxt;
    logic [ADDR_W-1:0]   addr_nxt;

    assign sel      = IOCTL_UPLOAD && (IOCTL_INDEX == SAVE_INDEX);
    assign in_range = (IOCTL_ADDR[24:ADDR_W] == '0);

`ifdef SRAM_UPLOAD_AUTOSAVE_EN
    localparam int CNT_W = $clog2(AUTOSAVE_FRAMES + 1);

    logic [CNT_W-1:0] quiet_cnt;
    logic             vsync_q;
    logic             auto_hit;

    assign auto_hit = (quiet_cnt == CNT_W'(AUTOSAVE_FRAMES));
    assign save_go  = DIRTY && (SAVE_TRIG || auto_hit);

    // Count quiet frames while dirty and idle; any write restarts it.
    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            quiet_cnt <= '0;
            vsync_q   <= 1'b0;
        end else begin
            vsync_q <= VSYNC;
            if (MEM_WE_SNOOP || state != IDLE || !DIRTY)
                quiet_cnt <= '0;
            else if (VSYNC && !vsync_q && !auto_hit)
                quiet_cnt <= quiet_cnt + 1'b1;
        end
    end
`else
    logic unused_vsync;

    assign unused_vsync = VSYNC;
    assign save_go      = DIRTY && SAVE_TRIG;
`endif

    // State and registered ioctl/memory outputs.
    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            state      <= IDLE;
            IOCTL_DIN  <= 8'h00;
            IOCTL_WAIT <= 1'b0;
            MEM_RD     <= 1'b0;
            MEM_ADDR   <= '0;
        end else begin
            state      <= state_nxt;
            IOCTL_DIN  <= din_nxt;
            IOCTL_WAIT <= wait_nxt;
            MEM_RD     <= rd_nxt;
            MEM_ADDR   <= addr_nxt;
        end
    end

    // A write wins over upload completion so no change is lost.
    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB)
            DIRTY <= 1'b0;
        else if (MEM_WE_SNOOP)
            DIRTY <= 1'b1;
        else if (clr_dirty)
            DIRTY <= 1'b0;
    end

    // Next-state and next-output decode.
    always_comb begin
        state_nxt = state;
        din_nxt   = IOCTL_DIN;
        wait_nxt  = IOCTL_WAIT;
        rd_nxt    = 1'b0;
        addr_nxt  = MEM_ADDR;
        clr_dirty = 1'b0;
        unique case (state)
            IDLE: begin
                if (sel)
                    state_nxt = ACTIVE;
                else if (save_go)
                    state_nxt = REQ;
            end
            REQ: begin
                if (sel)
                    state_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (!sel) begin
                    state_nxt = IDLE;
                    clr_dirty = 1'b1;
                end else if (IOCTL_RD) begin
                    if (in_range) begin
                        rd_nxt    = 1'b1;
                        addr_nxt  = IOCTL_ADDR[ADDR_W-1:0];
                        wait_nxt  = 1'b1;
                        state_nxt = FETCH;
                    end else begin
                        din_nxt = 8'hFF;
                    end
                end
            end
            FETCH: begin
                if (!sel) begin
                    state_nxt = IDLE;
                    wait_nxt  = 1'b0;
                end else if (MEM_VALID) begin
                    din_nxt   = MEM_DATA;
                    wait_nxt  = 1'b0;
                    state_nxt = ACTIVE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign UPLOAD_REQ = (state == REQ);
    assign BUSY       = (state != IDLE);

endmodule

// File: tb/tb_sram_upload.sv
// Bench for sram_upload: scenario tasks with a read-data scoreboard.
// Build with SRAM_UPLOAD_AUTOSAVE_EN to exercise the autosave path.
module tb_sram_upload;

    logic        CLK = 1'b0;
    logic        RESB = 1'b0;
    logic        SAVE_TRIG = 1'b0;
    logic        VSYNC = 1'b0;
    logic        IOCTL_UPLOAD = 1'b0;
    logic [7:0]  IOCTL_INDEX = 8'd0;
    logic        IOCTL_RD = 1'b0;
    logic [24:0] IOCTL_ADDR = '0;
    logic [7:0]  IOCTL_DIN;
    logic        IOCTL_WAIT;
    logic        UPLOAD_REQ;
    logic        MEM_RD;
    logic [12:0] MEM_ADDR;
    logic [7:0]  MEM_DATA = 8'h00;
    logic        MEM_VALID = 1'b0;
    logic        MEM_WE_SNOOP = 1'b0;
    logic        DIRTY;
    logic        BUSY;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    sram_upload #(
        .ADDR_W(13),
        .SAVE_INDEX(8'd1),
        .AUTOSAVE_FRAMES(4)
    ) dut (
        .CLK(CLK),
        .RESB(RESB),
        .SAVE_TRIG(SAVE_TRIG),
        .VSYNC(VSYNC),
        .IOCTL_UPLOAD(IOCTL_UPLOAD),
        .IOCTL_INDEX(IOCTL_INDEX),
        .IOCTL_RD(IOCTL_RD),
        .IOCTL_ADDR(IOCTL_ADDR),
        .IOCTL_DIN(IOCTL_DIN),
        .IOCTL_WAIT(IOCTL_WAIT),
        .UPLOAD_REQ(UPLOAD_REQ),
        .MEM_RD(MEM_RD),
        .MEM_ADDR(MEM_ADDR),
        .MEM_DATA(MEM_DATA),
        .MEM_VALID(MEM_VALID),
        .MEM_WE_SNOOP(MEM_WE_SNOOP),
        .DIRTY(DIRTY),
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] pat(input logic [12:0] a);
        return a[7:0] ^ {a[12:8], 3'b101};
    endfunction

    // Strobe one read; act as the RAM answering after lat cycles.
    task automatic ioctl_read(input logic [24:0] a, input int lat,
                              input logic [7:0] d,
                              output logic [7:0] din, output int wc,
                              output int rc, output logic [12:0] ma,
                              output bit to);
        wc = 0; rc = 0; ma = '0; to = 1'b1;
        @(negedge CLK); IOCTL_RD = 1'b1; IOCTL_ADDR = a;
        @(negedge CLK); IOCTL_RD = 1'b0;
        for (int c = 1; c <= 64; c++) begin
            if (MEM_RD) begin rc++; ma = MEM_ADDR; end
            if (!IOCTL_WAIT) begin to = 1'b0; break; end
            wc++;
            MEM_VALID = (c == lat);
            MEM_DATA  = d;
            @(negedge CLK);
        end
        MEM_VALID = 1'b0;
        din = IOCTL_DIN;
    endtask

    task automatic pulse_snoop();
        @(negedge CLK); MEM_WE_SNOOP = 1'b1;
        @(negedge CLK); MEM_WE_SNOOP = 1'b0;
    endtask

    task automatic pulse_vsync();
        @(negedge CLK); VSYNC = 1'b1;
        @(negedge CLK); VSYNC = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RESB = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({IOCTL_DIN, IOCTL_WAIT, UPLOAD_REQ, MEM_RD, MEM_ADDR, DIRTY, BUSY}
            !== 26'd0) begin
            errors++;
            $display("FAIL reset_vals got din=%h w=%b req=%b rd=%b a=%h d=%b b=%b want all 0",
                     IOCTL_DIN, IOCTL_WAIT, UPLOAD_REQ, MEM_RD, MEM_ADDR, DIRTY, BUSY);
        end
        RESB = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_save_trig();
        pulse_snoop();
        checks++;
        if (DIRTY !== 1'b1) begin
            errors++; $display("FAIL dirty_set got %b want 1", DIRTY);
        end
        @(negedge CLK); SAVE_TRIG = 1'b1;
        @(negedge CLK); SAVE_TRIG = 1'b0;
        checks++;
        if (UPLOAD_REQ !== 1'b1 || BUSY !== 1'b1) begin
            errors++; $display("FAIL upload_req got req=%b busy=%b want 1 1", UPLOAD_REQ, BUSY);
        end
        IOCTL_UPLOAD = 1'b1; IOCTL_INDEX = 8'd2;
        @(negedge CLK);
        checks++;
        if (UPLOAD_REQ !== 1'b1) begin
            errors++; $display("FAIL wrong_index got req=%b want 1", UPLOAD_REQ);
        end
        IOCTL_INDEX = 8'd1;
        @(negedge CLK);
        checks++;
        if (UPLOAD_REQ !== 1'b0 || BUSY !== 1'b1) begin
            errors++; $display("FAIL enter_active got req=%b busy=%b want 0 1", UPLOAD_REQ, BUSY);
        end
    endtask

    task automatic test_read();
        logic [7:0] din, e;
        logic [12:0] ma;
        int wc, rc;
        bit to;
        exp_q.push_back(8'hA5);
        ioctl_read(25'h0005, 3, 8'hA5, din, wc, rc, ma, to);
        e = exp_q.pop_front();
        checks++;
        if (to || din !== e || wc != 3 || rc != 1 || ma !== 13'h0005) begin
            errors++;
            $display("FAIL read_5 got din=%h wait=%0d rd=%0d addr=%h to=%b want %h 3 1 0005 0",
                     din, wc, rc, ma, to, e);
        end
        exp_q.push_back(8'h3C);
        ioctl_read(25'h1FFF, 6, 8'h3C, din, wc, rc, ma, to);
        e = exp_q.pop_front();
        checks++;
        if (to || din !== e || wc != 6 || rc != 1 || ma !== 13'h1FFF) begin
            errors++;
            $display("FAIL read_top got din=%h wait=%0d rd=%0d addr=%h to=%b want %h 6 1 1fff 0",
                     din, wc, rc, ma, to, e);
        end
        for (int k = 0; k < 2; k++) begin
            logic [24:0] oa;
            oa = (k == 0) ? 25'h0002000 : 25'h1FFFFFF;
            exp_q.push_back(8'hFF);
            ioctl_read(oa, 2, 8'h11, din, wc, rc, ma, to);
            e = exp_q.pop_front();
            checks++;
            if (to || din !== e || wc != 0 || rc != 0) begin
                errors++;
                $display("FAIL read_oob addr=%h got din=%h wait=%0d rd=%0d want %h 0 0",
                         oa, din, wc, rc, e);
            end
        end
    endtask

    task automatic test_full_upload();
        logic [7:0] din, e;
        logic [12:0] ma;
        int wc, rc;
        bit to;
        for (int a = 0; a < 8192; a++) begin
            exp_q.push_back(pat(13'(a)));
            ioctl_read(25'(a), 2, pat(13'(a)), din, wc, rc, ma, to);
            e = exp_q.pop_front();
            checks++;
            if (to || din !== e || ma !== 13'(a)) begin
                errors++;
                $display("FAIL full_byte addr=%h got din=%h maddr=%h to=%b want %h",
                         a, din, ma, to, e);
            end
        end
        @(negedge CLK); IOCTL_UPLOAD = 1'b0;
        @(negedge CLK);
        checks++;
        if (DIRTY !== 1'b0 || BUSY !== 1'b0) begin
            errors++; $display("FAIL full_done got dirty=%b busy=%b want 0 0", DIRTY, BUSY);
        end
    endtask

    task automatic test_snoop_on_complete();
        @(negedge CLK); IOCTL_UPLOAD = 1'b1;
        @(negedge CLK);
        checks++;
        if (BUSY !== 1'b1 || UPLOAD_REQ !== 1'b0) begin
            errors++; $display("FAIL hps_start got busy=%b req=%b want 1 0", BUSY, UPLOAD_REQ);
        end
        IOCTL_UPLOAD = 1'b0; MEM_WE_SNOOP = 1'b1;
        @(negedge CLK); MEM_WE_SNOOP = 1'b0;
        checks++;
        if (DIRTY !== 1'b1 || BUSY !== 1'b0) begin
            errors++; $display("FAIL snoop_done got dirty=%b busy=%b want 1 0", DIRTY, BUSY);
        end
    endtask

    task automatic test_abort();
        @(negedge CLK); IOCTL_UPLOAD = 1'b1;
        @(negedge CLK); IOCTL_RD = 1'b1; IOCTL_ADDR = 25'h7;
        @(negedge CLK); IOCTL_RD = 1'b0;
        checks++;
        if (IOCTL_WAIT !== 1'b1 || MEM_RD !== 1'b1) begin
            errors++; $display("FAIL abort_fetch got wait=%b rd=%b want 1 1", IOCTL_WAIT, MEM_RD);
        end
        IOCTL_UPLOAD = 1'b0;
        @(negedge CLK);
        checks++;
        if (IOCTL_WAIT !== 1'b0 || BUSY !== 1'b0 || DIRTY !== 1'b1) begin
            errors++;
            $display("FAIL abort got wait=%b busy=%b dirty=%b want 0 0 1", IOCTL_WAIT, BUSY, DIRTY);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge CLK); IOCTL_UPLOAD = 1'b1;
        @(negedge CLK); IOCTL_RD = 1'b1; IOCTL_ADDR = 25'h9;
        @(negedge CLK); IOCTL_RD = 1'b0;
        #1 RESB = 1'b0;
        #1;
        checks++;
        if (IOCTL_WAIT !== 1'b0 || MEM_RD !== 1'b0 || BUSY !== 1'b0 ||
            DIRTY !== 1'b0 || MEM_ADDR !== 13'h0) begin
            errors++;
            $display("FAIL reset_mid got wait=%b rd=%b busy=%b dirty=%b a=%h want 0 0 0 0 0",
                     IOCTL_WAIT, MEM_RD, BUSY, DIRTY, MEM_ADDR);
        end
        IOCTL_UPLOAD = 1'b0;
        @(negedge CLK); RESB = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_save_clean();
        @(negedge CLK); SAVE_TRIG = 1'b1;
        @(negedge CLK); SAVE_TRIG = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (UPLOAD_REQ !== 1'b0 || BUSY !== 1'b0) begin
                errors++; $display("FAIL save_clean got req=%b busy=%b want 0 0", UPLOAD_REQ, BUSY);
            end
            @(negedge CLK);
        end
    endtask

`ifdef SRAM_UPLOAD_AUTOSAVE_EN
    task automatic test_autosave();
        bit seen;
        pulse_snoop();
        repeat (3) pulse_vsync();
        checks++;
        if (UPLOAD_REQ !== 1'b0) begin
            errors++; $display("FAIL auto_early1 got req=%b want 0", UPLOAD_REQ);
        end
        pulse_snoop();
        repeat (3) pulse_vsync();
        checks++;
        if (UPLOAD_REQ !== 1'b0) begin
            errors++; $display("FAIL auto_early2 got req=%b want 0", UPLOAD_REQ);
        end
        @(negedge CLK); VSYNC = 1'b1;
        @(negedge CLK); VSYNC = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge CLK);
            seen = (UPLOAD_REQ === 1'b1);
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL auto_fire got req=%b want 1 within 4 cycles", UPLOAD_REQ);
        end
    endtask
`else
    task automatic test_autosave();
        pulse_snoop();
        repeat (6) pulse_vsync();
        checks++;
        if (UPLOAD_REQ !== 1'b0 || BUSY !== 1'b0) begin
            errors++; $display("FAIL no_auto got req=%b busy=%b want 0 0", UPLOAD_REQ, BUSY);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_save_trig();
        test_read();
        test_full_upload();
        test_snoop_on_complete();
        test_abort();
        test_reset_mid();
        test_save_clean();
        test_autosave();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
